bp_resolve_queue: RTL and testbench

// - Downstream consumer of the 2-bit predictor: queues each issued prediction (predicted direction + tag)
//   in order until the branch resolves, then checks it against the actual outcome.
// - Per resolution: one-cycle mispredict pulse with the offending tag, wrong-path flush of younger entries,
//   and saturating correct/mispredict statistics for the accuracy bench.

---
 rtl/bp_resolve_queue.sv | 131 +++++++++++++
 tb/tb_bp_resolve_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_resolve_queue.sv
// In-order queue of issued branch predictions, scored against resolved outcomes.
// Produces mispredict/tag-error pulses, wrong-path flushes and saturating accuracy counters.
module bp_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [TAG_W-1:0]           pred_tag,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic [TAG_W-1:0]           res_tag,
  output logic                       mispredict,
  output logic [TAG_W-1:0]           mispredict_tag,
  output logic                       tag_error,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           correct_cnt,
  output logic [CNT_W-1:0]           mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [TAG_W:0]     mem_q [DEPTH];

  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               mispredict_q, mispredict_d;
  logic [TAG_W-1:0]   mispredict_tag_q, mispredict_tag_d;
  logic               tag_error_q, tag_error_d;
  logic [CNT_W-1:0]   correct_cnt_q, correct_cnt_d;
  logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

  logic               full;
  logic               empty;
  logic               enq;
  logic               pop;
  logic               wrong_dir;
  logic               head_taken;
  logic [TAG_W-1:0]   head_tag;

  assign full       = (occ_q == OCC_W'(DEPTH));
  assign empty      = (occ_q == '0);
  assign enq        = pred_valid && !full;
  assign pop        = res_valid && !empty;
  assign head_taken = mem_q[rd_ptr_q][TAG_W];
  assign head_tag   = mem_q[rd_ptr_q][TAG_W-1:0];
  assign wrong_dir  = pop && (head_taken != res_taken);

  // Entry storage carries no reset; validity is tracked by the pointers.
  // A wrong-path write during a flush lands beyond the new tail and is never read.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= {pred_taken, pred_tag};
    end
  end

  always_comb begin
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    occ_d            = occ_q;
    mispredict_d     = 1'b0;
    mispredict_tag_d = mispredict_tag_q;
    tag_error_d      = 1'b0;
    correct_cnt_d    = correct_cnt_q;
    mispred_cnt_d    = mispred_cnt_q;

    if (res_valid && (empty || (res_tag != head_tag))) begin
      tag_error_d = 1'b1;
    end

    if (wrong_dir) begin
      // Everything younger than the mispredicted head is wrong-path, including a same-cycle enqueue.
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      wr_ptr_d         = rd_ptr_q + PTR_W'(1);
      occ_d            = '0;
      mispredict_d     = 1'b1;
      mispredict_tag_d = head_tag;
      if (mispred_cnt_q != '1) begin
        mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (correct_cnt_q != '1) begin
          correct_cnt_d = correct_cnt_q + CNT_W'(1);
        end
      end
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + OCC_W'(enq) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      occ_q            <= '0;
      mispredict_q     <= 1'b0;
      mispredict_tag_q <= '0;
      tag_error_q      <= 1'b0;
      correct_cnt_q    <= '0;
      mispred_cnt_q    <= '0;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      occ_q            <= occ_d;
      mispredict_q     <= mispredict_d;
      mispredict_tag_q <= mispredict_tag_d;
      tag_error_q      <= tag_error_d;
      correct_cnt_q    <= correct_cnt_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign pred_ready     = !full;
  assign mispredict     = mispredict_q;
  assign mispredict_tag = mispredict_tag_q;
  assign tag_error      = tag_error_q;
  assign occupancy      = occ_q;
  assign correct_cnt    = correct_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Randomized and directed bench for bp_resolve_queue against a queue-based reference model.
// Built with CNT_W=4 so counter saturation is reachable in a short run.
module tb_bp_resolve_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clk;
  logic                   reset;
  logic                   pred_valid;
  logic                   pred_taken;
  logic [TAG_W-1:0]       pred_tag;
  logic                   pred_ready;
  logic                   res_valid;
  logic                   res_taken;
  logic [TAG_W-1:0]       res_tag;
  logic                   mispredict;
  logic [TAG_W-1:0]       mispredict_tag;
  logic                   tag_error;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0]       correct_cnt;
  logic [CNT_W-1:0]       mispred_cnt;

  bp_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .pred_valid     (pred_valid),
    .pred_taken     (pred_taken),
    .pred_tag       (pred_tag),
    .pred_ready     (pred_ready),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_tag        (res_tag),
    .mispredict     (mispredict),
    .mispredict_tag (mispredict_tag),
    .tag_error      (tag_error),
    .occupancy      (occupancy),
    .correct_cnt    (correct_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             taken;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t mq[$];
  int     mCorrect;
  int     mMispred;
  logic   mMis;
  logic   mTagErr;
  logic [TAG_W-1:0] mMisTag;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, observed, expected, $time);
    end
  endtask

  // Reference behaviour: an in-order list of predictions scored as each resolution arrives.
  task automatic modelStep(input logic pv, input logic pt, input logic [TAG_W-1:0] ptg,
                           input logic rv, input logic rt, input logic [TAG_W-1:0] rtg,
                           input logic rst);
    bit     doEnq;
    entry_t head;
    mMis    = 1'b0;
    mTagErr = 1'b0;
    if (rst) begin
      mq.delete();
      mCorrect = 0;
      mMispred = 0;
      mMisTag  = '0;
      return;
    end
    doEnq = pv && (mq.size() < DEPTH);
    if (rv) begin
      if (mq.size() == 0) begin
        mTagErr = 1'b1;
      end else begin
        head = mq.pop_front();
        if (head.tag != rtg) mTagErr = 1'b1;
        if (head.taken == rt) begin
          if (mCorrect < CNT_MAX) mCorrect++;
        end else begin
          if (mMispred < CNT_MAX) mMispred++;
          mMis    = 1'b1;
          mMisTag = head.tag;
          mq.delete();
          doEnq = 1'b0;
        end
      end
    end
    if (doEnq) mq.push_back({pt, ptg});
  endtask

  task automatic compareAll();
    checkOutput("occupancy", 32'(occupancy), 32'(mq.size()));
    checkOutput("pred_ready", 32'(pred_ready), 32'(mq.size() < DEPTH));
    checkOutput("mispredict", 32'(mispredict), 32'(mMis));
    checkOutput("mispredict_tag", 32'(mispredict_tag), 32'(mMisTag));
    checkOutput("tag_error", 32'(tag_error), 32'(mTagErr));
    checkOutput("correct_cnt", 32'(correct_cnt), 32'(mCorrect));
    checkOutput("mispred_cnt", 32'(mispred_cnt), 32'(mMispred));
  endtask

  task automatic applyStimulus(input logic pv, input logic pt, input logic [TAG_W-1:0] ptg,
                               input logic rv, input logic rt, input logic [TAG_W-1:0] rtg,
                               input logic rst);
    pred_valid = pv;
    pred_taken = pt;
    pred_tag   = ptg;
    res_valid  = rv;
    res_taken  = rt;
    res_tag    = rtg;
    reset      = rst;
    @(posedge clk);
    modelStep(pv, pt, ptg, rv, rt, rtg, rst);
    #1;
    compareAll();
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic doEnq(input logic [TAG_W-1:0] tg, input logic tk);
    applyStimulus(1, tk, tg, 0, 0, 0, 0);
  endtask

  task automatic doRes(input logic [TAG_W-1:0] tg, input logic tk);
    applyStimulus(0, 0, 0, 1, tk, tg, 0);
  endtask

  task automatic doIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic             rv, rt, pv;
    logic [TAG_W-1:0] rtg;
    mq.delete();
    mCorrect = 0;
    mMispred = 0;
    mMisTag  = '0;
    mMis     = 0;
    mTagErr  = 0;
    pred_valid = 0; pred_taken = 0; pred_tag = 0;
    res_valid = 0; res_taken = 0; res_tag = 0;
    reset = 1;

    doReset();
    doReset();
    checkOutput("reset_occ", 32'(occupancy), 0);
    checkOutput("reset_ready", 32'(pred_ready), 1);

    doEnq(8'd1, 1'b1);
    doEnq(8'd2, 1'b0);
    doEnq(8'd3, 1'b1);
    checkOutput("three_enq_occ", 32'(occupancy), 3);

    doRes(8'd1, 1'b1);
    doRes(8'd2, 1'b0);
    checkOutput("two_correct_cnt", 32'(correct_cnt), 2);
    checkOutput("two_correct_occ", 32'(occupancy), 1);

    for (int t = 4; t <= 7; t++) doEnq(8'(t), 1'b1);
    doRes(8'd3, 1'b1);
    applyStimulus(1, 1, 8'd8, 1, 0, 8'd4, 0);
    checkOutput("flush_mispredict", 32'(mispredict), 1);
    checkOutput("flush_tag", 32'(mispredict_tag), 4);
    checkOutput("flush_occ", 32'(occupancy), 0);
    checkOutput("flush_mcnt", 32'(mispred_cnt), 1);
    doIdle();
    checkOutput("pulse_one_cycle", 32'(mispredict), 0);
    checkOutput("tag_held", 32'(mispredict_tag), 4);

    for (int t = 10; t < 18; t++) doEnq(8'(t), 1'b1);
    checkOutput("full_ready", 32'(pred_ready), 0);
    doEnq(8'd18, 1'b1);
    checkOutput("dropped_occ", 32'(occupancy), 8);
    doRes(8'd10, 1'b1);
    checkOutput("after_pop_occ", 32'(occupancy), 7);
    checkOutput("after_pop_ready", 32'(pred_ready), 1);
    for (int t = 20; t < 40; t++) begin
      applyStimulus(1, t[0], 8'(t), 1, mq[0].taken, mq[0].tag, 0);
    end

    doReset();
    doRes(8'd9, 1'b1);
    checkOutput("empty_res_terr", 32'(tag_error), 1);
    checkOutput("empty_res_ccnt", 32'(correct_cnt), 0);
    applyStimulus(1, 1, 8'd6, 1, 1, 8'd6, 0);
    checkOutput("empty_res_enq_occ", 32'(occupancy), 1);
    doRes(8'd6, 1'b1);
    doEnq(8'd5, 1'b0);
    doRes(8'd9, 1'b0);
    checkOutput("bad_tag_terr", 32'(tag_error), 1);
    checkOutput("bad_tag_popped", 32'(occupancy), 0);

    doReset();
    for (int i = 0; i < 20; i++) begin
      doEnq(8'(i), 1'b0);
      doRes(8'(i), 1'b0);
    end
    checkOutput("sat_correct", 32'(correct_cnt), CNT_MAX);
    for (int i = 0; i < 20; i++) begin
      doEnq(8'(i), 1'b1);
      doRes(8'(i), 1'b0);
    end
    checkOutput("sat_mispred", 32'(mispred_cnt), CNT_MAX);
    doEnq(8'd1, 1'b1);
    doEnq(8'd2, 1'b1);
    applyStimulus(1, 1, 8'd3, 1, 0, 8'd1, 1);
    checkOutput("midreset_occ", 32'(occupancy), 0);
    checkOutput("midreset_mis", 32'(mispredict), 0);
    checkOutput("midreset_tag", 32'(mispredict_tag), 0);
    checkOutput("midreset_ccnt", 32'(correct_cnt), 0);

    for (int i = 0; i < 3000; i++) begin
      pv  = ($urandom_range(99) < 60);
      rv  = ($urandom_range(99) < 45);
      if (mq.size() > 0 && $urandom_range(9) != 0) rtg = mq[0].tag;
      else rtg = 8'($urandom);
      if (mq.size() > 0) rt = ($urandom_range(7) == 0) ? ~mq[0].taken : mq[0].taken;
      else rt = 1'($urandom);
      applyStimulus(pv, 1'($urandom), 8'($urandom), rv, rt, rtg, ($urandom_range(199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
